s7_stoper_ctrl: RTL and testbench
=================================

// Module: s7_stoper_ctrl
// PURPOSE
//  Parametrised stopwatch with start/stop, lap-freeze and clear controls, driving a
//  multiplexed DISPLAYS_NUM-digit 7-segment display. Holds a BCD time counter
//  (hundredths, seconds, minutes, hours), a control FSM, a tick prescaler and a digit
//  scanner. Top-level display block for the board; replaces the free-running stopwatch.
// PARAMETERS
//  DISPLAYS_NUM  6       digits shown/counted, legal 2..8; digit 0 = least significant
//  TICK_DIV      500000  i_clk cycles per 1/100 s tick, >=2
//  SCAN_DIV      50000   i_clk cycles per digit-scan step, >=2
// PORTS
//  i_clk           in   1                  system clock
//  i_rst           in   1                  asynchronous reset, active-low
//  i_start_stop    in   1                  start/stop button, async level, acts on rising edge
//  i_lap           in   1                  lap button, async level, acts on rising edge
//  i_clear         in   1                  clear button, async level, acts on rising edge
//  o_segments      out  7                  segments {g,f,e,d,c,b,a}, active-high
//  o_segments_sel  out  DISPLAYS_NUM       one-hot digit select, active-high
//  o_bcd_time      out  4*DISPLAYS_NUM     displayed BCD value, digit k at [4k+3:4k]
//  o_running       out  1                  1 in RUN or LAP
//  o_lap_active    out  1                  1 in LAP (display frozen)
//  o_overflow      out  1                  1-cycle pulse when the counter wraps to all-zero
// BEHAVIOUR
//  Reset (i_rst=0, async): FSM=IDLE, counter=0, prescaler=0, scan index=0, lap reg=0;
//   o_segments=7'h00, o_segments_sel=0, o_bcd_time=0, o_running=0, o_lap_active=0,
//   o_overflow=0. Reset mid-count discards all state; no event is remembered.
//  Inputs: each passes a 2-flop synchroniser, then rising-edge detect -> 1-cycle event.
//   Input rising before edge k is acted on by the FSM at edge k+3 (state visible after).
//  FSM (event priority clear > start_stop > lap; one transition per cycle):
//   IDLE : start_stop->RUN; lap, clear ignored.
//   RUN  : start_stop->STOP; lap->LAP (lap reg <= live counter); clear ignored.
//   LAP  : lap->RUN (lap reg released); start_stop->STOP; clear ignored.
//   STOP : start_stop->RUN; clear->IDLE (counter=0, prescaler=0); lap ignored.
//  Prescaler: counts 0..TICK_DIV-1 only in RUN/LAP; held in STOP/IDLE (fraction kept).
//   Tick on terminal count; counter increments in the same cycle.
//  Counter: digit pairs [1:0] 00..99, [3:2] 00..59, [5:4] 00..59, [7:6] 00..99;
//   only DISPLAYS_NUM digits exist (odd count: top digit counts 0..9 or 0..5 per its
//   position). Carry ripples within one cycle. At all-max, tick -> all-zero, o_overflow=1
//   for that cycle, counting continues.
//  Displayed value: o_bcd_time = lap reg in LAP, else live counter; registered, 1 cycle
//   after counter/lap update. Counter keeps running under a frozen display.
//  Scanner: free-running divider 0..SCAN_DIV-1; on terminal count, index advances
//   0,1..DISPLAYS_NUM-1,0. o_segments_sel=1<<index, o_segments=decode(digit[index]),
//   both registered and updated together: no cycle mixes digit k's select and k+1's data.
//   First non-zero select appears SCAN_DIV cycles after reset release.
//  Decode: 0..9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F; codes A..F -> 7'h00 (blank).
// TESTING  (bench: TICK_DIV=4, SCAN_DIV=2, DISPLAYS_NUM=6)
//  Reset mid-RUN, counter 000123 -> all outputs 0 same cycle; after release, IDLE, sel=0
//   for 2 cycles then 6'b000001, segments 3F.
//  start_stop pulse, wait 40 clocks -> o_running=1 at edge+3, o_bcd_time=24'h000010;
//   start_stop again -> holds 000010 indefinitely; start_stop -> resumes from same fraction.
//  RUN, lap at 000005 -> o_bcd_time frozen 000005, o_lap_active=1; after 20 more clocks
//   lap -> o_bcd_time=24'h000010.
//  Carry/wrap: preload counter 005999 (force) + 1 tick -> 010000; 595999 + 1 tick ->
//   000000 with 1-cycle o_overflow.
//  Simultaneous clear+start_stop in STOP -> IDLE, counter 0; clear in RUN/LAP/IDLE -> ignored.
//  Scan: counter 123456 -> sel cycles 000001..100000 every 2 clocks, segments 7D,6D,66,4F,5B,06.

Source files
------------

// File: rtl/s7_stoper_ctrl.sv
// s7_stoper_ctrl
//   Stopwatch with start/stop, lap-freeze and clear buttons. It holds a BCD time
//   counter (hundredths, seconds, minutes, hours), a control FSM, a 1/100 s tick
//   prescaler and a digit scanner for a multiplexed 7-segment display.
// Ports
//   i_clk           system clock
//   i_rst           asynchronous reset, active-low
//   i_start_stop    start/stop button (async level, acts on rising edge)
//   i_lap           lap button (async level, acts on rising edge)
//   i_clear         clear button (async level, acts on rising edge)
//   o_segments      segments {g,f,e,d,c,b,a}, active-high
//   o_segments_sel  one-hot digit select, active-high
//   o_bcd_time      displayed BCD value, digit k at [4k+3:4k]
//   o_running       high in RUN or LAP
//   o_lap_active    high in LAP (display frozen)
//   o_overflow      one-cycle pulse when the counter wraps to all-zero
module s7_stoper_ctrl #(
  parameter int DISPLAYS_NUM = 6,
  parameter int TICK_DIV     = 500000,
  parameter int SCAN_DIV     = 50000
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start_stop,
  input  logic                      i_lap,
  input  logic                      i_clear,
  output logic [6:0]                o_segments,
  output logic [DISPLAYS_NUM-1:0]   o_segments_sel,
  output logic [4*DISPLAYS_NUM-1:0] o_bcd_time,
  output logic                      o_running,
  output logic                      o_lap_active,
  output logic                      o_overflow
);

  localparam int NW = 4 * DISPLAYS_NUM;
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DISPLAYS_NUM);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DISPLAYS_NUM - 1);

  typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;

  // ---------------------------------------------------------------------------
  // Button synchronisers and edge detect. Bit order {clear, lap, start_stop}.
  // The event is registered so an input edge reaches the FSM at edge k+3.
  // ---------------------------------------------------------------------------
  logic [2:0] meta_q, sync_q, prev_q, evt_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      evt_q  <= '0;
    end else begin
      meta_q <= {i_clear, i_lap, i_start_stop};
      sync_q <= meta_q;
      prev_q <= sync_q;
      evt_q  <= sync_q & ~prev_q;
    end
  end

  logic ss_evt, lap_evt, clr_evt;
  assign ss_evt  = evt_q[0];
  assign lap_evt = evt_q[1];
  assign clr_evt = evt_q[2];

  // ---------------------------------------------------------------------------
  // Control FSM with registered status outputs and the lap capture register.
  // ---------------------------------------------------------------------------
  state_t        state_q;
  logic          running_q, lap_active_q;
  logic [NW-1:0] lap_q, cnt_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= IDLE;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      lap_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ss_evt) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (ss_evt) begin
            state_q   <= STOP;
            running_q <= 1'b0;
          end else if (lap_evt) begin
            state_q      <= LAP;
            lap_active_q <= 1'b1;
            lap_q        <= cnt_q;
          end
        end
        LAP: begin
          if (ss_evt) begin
            state_q      <= STOP;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
          end else if (lap_evt) begin
            state_q      <= RUN;
            lap_active_q <= 1'b0;
          end
        end
        STOP: begin
          // clear outranks start_stop when both arrive together
          if (clr_evt) begin
            state_q <= IDLE;
          end else if (ss_evt) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= IDLE;
          running_q    <= 1'b0;
          lap_active_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler and BCD time counter. The carry ripples through every digit in
  // one cycle; the carry out of the top digit marks the wrap to all-zero.
  // ---------------------------------------------------------------------------
  logic [PW-1:0]         presc_q;
  logic                  overflow_q;
  logic                  counting, tick, clear_now;
  logic [DISPLAYS_NUM:0] carry;
  logic [NW-1:0]         cnt_inc;

  assign counting  = (state_q == RUN) || (state_q == LAP);
  assign tick      = counting && (presc_q == PRESC_LAST);
  assign clear_now = (state_q == STOP) && clr_evt;
  assign carry[0]  = tick;

  for (genvar gi = 0; gi < DISPLAYS_NUM; gi++) begin : g_digit
    // tens-of-seconds and tens-of-minutes stop at 5, every other digit at 9
    localparam logic [3:0] DMAX = ((gi == 3) || (gi == 5)) ? 4'd5 : 4'd9;
    logic [3:0] d;
    assign d            = cnt_q[4*gi +: 4];
    assign carry[gi+1]  = carry[gi] && (d == DMAX);
    assign cnt_inc[4*gi +: 4] = !carry[gi]  ? d     :
                                (d == DMAX) ? 4'd0  : d + 4'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      presc_q    <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= carry[DISPLAYS_NUM];
      if (clear_now) begin
        presc_q <= '0;
        cnt_q   <= '0;
      end else if (counting) begin
        presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        if (tick) cnt_q <= cnt_inc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Displayed value and digit scanner. Select and segment data load on the
  // same edge from the same index, so they never disagree.
  // ---------------------------------------------------------------------------
  logic [NW-1:0]           bcd_q;
  logic [SW-1:0]           scan_q;
  logic [IW-1:0]           idx_q;
  logic [DISPLAYS_NUM-1:0] sel_q;
  logic [6:0]              seg_q;
  logic [3:0]              disp_digit [DISPLAYS_NUM];

  for (genvar gi = 0; gi < DISPLAYS_NUM; gi++) begin : g_disp
    assign disp_digit[gi] = bcd_q[4*gi +: 4];
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      bcd_q  <= '0;
      scan_q <= '0;
      idx_q  <= '0;
      sel_q  <= '0;
      seg_q  <= 7'h00;
    end else begin
      bcd_q <= (state_q == LAP) ? lap_q : cnt_q;
      if (scan_q == SCAN_LAST) begin
        scan_q <= '0;
        sel_q  <= DISPLAYS_NUM'(1) << idx_q;
        seg_q  <= seg_decode(disp_digit[idx_q]);
        idx_q  <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        scan_q <= scan_q + 1'b1;
      end
    end
  end

  assign o_segments     = seg_q;
  assign o_segments_sel = sel_q;
  assign o_bcd_time     = bcd_q;
  assign o_running      = running_q;
  assign o_lap_active   = lap_active_q;
  assign o_overflow     = overflow_q;

endmodule

// File: tb/tb_s7_stoper_ctrl.sv
module tb_s7_stoper_ctrl;

  localparam int N = 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           ss, lap, clr;
  logic [6:0]     seg;
  logic [N-1:0]   sel;
  logic [4*N-1:0] bcd;
  logic           running, lap_act, ovf;

  int total = 0;
  int bad   = 0;

  localparam int SIG_SEG = 0, SIG_SEL = 1, SIG_BCD = 2, SIG_RUN = 3, SIG_LAP = 4, SIG_OVF = 5;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always #5 clk = ~clk;

  s7_stoper_ctrl #(
    .DISPLAYS_NUM(N),
    .TICK_DIV(4),
    .SCAN_DIV(2)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .i_start_stop(ss),
    .i_lap(lap),
    .i_clear(clr),
    .o_segments(seg),
    .o_segments_sel(sel),
    .o_bcd_time(bcd),
    .o_running(running),
    .o_lap_active(lap_act),
    .o_overflow(ovf)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      SIG_SEG: observe = 32'(seg);
      SIG_SEL: observe = 32'(sel);
      SIG_BCD: observe = 32'(bcd);
      SIG_RUN: observe = 32'(running);
      SIG_LAP: observe = 32'(lap_act);
      default: observe = 32'(ovf);
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, observe(e.sig), e.val);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds the buttons {clr,lap,ss} until just after the FSM edge that acts on them.
  task automatic press(input logic [2:0] m);
    {clr, lap, ss} = m;
    step(4);
    {clr, lap, ss} = 3'b000;
    $display("txn t=%0t buttons clr/lap/ss=%b bcd=%h run=%b lap=%b", $time, m, bcd, running, lap_act);
  endtask

  task automatic expect_all_zero(input string tag);
    expect_val({tag, "_seg"}, SIG_SEG, 0);
    expect_val({tag, "_sel"}, SIG_SEL, 0);
    expect_val({tag, "_bcd"}, SIG_BCD, 0);
    expect_val({tag, "_run"}, SIG_RUN, 0);
    expect_val({tag, "_lap"}, SIG_LAP, 0);
    expect_val({tag, "_ovf"}, SIG_OVF, 0);
  endtask

  // Called on the negedge where reset was released.
  task automatic scan_after_reset(input string tag);
    expect_val({tag, "_sel0"}, SIG_SEL, 0);
    check_now();
    step(1);
    expect_val({tag, "_sel1"}, SIG_SEL, 0);
    check_now();
    step(1);
    expect_val({tag, "_sel2"}, SIG_SEL, 32'h01);
    expect_val({tag, "_seg2"}, SIG_SEG, 32'h3F);
    expect_val({tag, "_run"},  SIG_RUN, 0);
    expect_val({tag, "_bcd"},  SIG_BCD, 0);
    check_now();
  endtask

  task automatic preload(input logic [23:0] v);
    force dut.cnt_q = v;
    step(2);
    release dut.cnt_q;
    step(1);
  endtask

  task automatic stop_and_clear();
    press(3'b001);
    step(2);
    press(3'b101);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t want <1000000", $time);
    $fatal(1);
  end

  initial begin
    logic [23:0] scan_val;
    logic [3:0]  dig;
    int          waited;

    rst_n = 1'b0;
    {clr, lap, ss} = 3'b000;
    step(2);
    expect_all_zero("reset");
    check_now();
    rst_n = 1'b1;
    scan_after_reset("init");

    // clear and lap are ignored in IDLE
    press(3'b100);
    expect_val("idle_clr_run", SIG_RUN, 0);
    expect_val("idle_clr_bcd", SIG_BCD, 0);
    press(3'b010);
    check_now();
    expect_val("idle_lap_act", SIG_LAP, 0);
    expect_val("idle_lap_run", SIG_RUN, 0);
    check_now();

    // start: running appears right after the third edge following the input edge
    ss = 1'b1;
    step(3);
    expect_val("start_edge2", SIG_RUN, 0);
    check_now();
    step(1);
    expect_val("start_edge3", SIG_RUN, 1);
    check_now();
    ss = 1'b0;
    $display("txn t=%0t start_stop press, running=%b", $time, running);

    // 42 running edges: 10 ticks, fraction 2 left in the prescaler
    step(38);
    press(3'b001);
    expect_val("stop_run", SIG_RUN, 0);
    expect_val("stop_bcd", SIG_BCD, 32'h000010);
    check_now();
    step(30);
    expect_val("stop_hold", SIG_BCD, 32'h000010);
    check_now();

    // resume: kept fraction gives the next tick two edges in
    press(3'b001);
    expect_val("resume_run", SIG_RUN, 1);
    check_now();
    step(2);
    expect_val("resume_frac_a", SIG_BCD, 32'h000010);
    check_now();
    step(1);
    expect_val("resume_frac_b", SIG_BCD, 32'h000011);
    check_now();

    // clear together with start_stop while stopped goes to IDLE
    press(3'b001);
    step(2);
    press(3'b101);
    expect_val("clr_ss_run", SIG_RUN, 0);
    check_now();
    step(1);
    expect_val("clr_ss_bcd", SIG_BCD, 0);
    check_now();

    // lap freezes at 000005 while the counter runs on
    press(3'b001);
    step(19);
    press(3'b010);
    expect_val("lap_on", SIG_LAP, 1);
    expect_val("lap_run", SIG_RUN, 1);
    check_now();
    press(3'b100);
    expect_val("lap_clr_ign", SIG_LAP, 1);
    expect_val("lap_frozen_a", SIG_BCD, 32'h000005);
    check_now();
    step(9);
    expect_val("lap_frozen_b", SIG_BCD, 32'h000005);
    check_now();
    press(3'b010);
    expect_val("lap_off", SIG_LAP, 0);
    expect_val("lap_off_bcd", SIG_BCD, 32'h000005);
    check_now();
    step(1);
    expect_val("lap_release", SIG_BCD, 32'h000010);
    check_now();
    press(3'b100);
    expect_val("run_clr_ign", SIG_RUN, 1);
    check_now();
    step(2);
    stop_and_clear();

    // seconds/minutes carry
    preload(24'h005999);
    expect_val("preload_a", SIG_BCD, 32'h005999);
    check_now();
    press(3'b001);
    step(3);
    expect_val("carry_pre", SIG_BCD, 32'h005999);
    check_now();
    step(2);
    expect_val("carry_post", SIG_BCD, 32'h010000);
    check_now();
    stop_and_clear();

    // full wrap with overflow pulse
    preload(24'h595999);
    press(3'b001);
    step(3);
    expect_val("ovf_pre", SIG_OVF, 0);
    check_now();
    step(1);
    expect_val("ovf_pulse", SIG_OVF, 1);
    expect_val("ovf_bcd_a", SIG_BCD, 32'h595999);
    check_now();
    step(1);
    expect_val("ovf_end", SIG_OVF, 0);
    expect_val("ovf_bcd_b", SIG_BCD, 32'h000000);
    expect_val("ovf_run", SIG_RUN, 1);
    check_now();
    step(4);
    expect_val("wrap_continue", SIG_BCD, 32'h000001);
    check_now();
    stop_and_clear();

    // scanner over 123456
    scan_val = 24'h123456;
    preload(scan_val);
    step(14);
    waited = 0;
    while (sel !== 6'b000001 && waited < 16) begin
      step(1);
      waited++;
    end
    for (int d = 0; d < N; d++) begin
      dig = scan_val[4*d +: 4];
      expect_val($sformatf("scan_sel%0d", d), SIG_SEL, 32'(1) << d);
      expect_val($sformatf("scan_seg%0d", d), SIG_SEG, 32'(seg_tab[dig]));
      check_now();
      $display("txn t=%0t scan digit %0d sel=%b seg=%h", $time, d, sel, seg);
      step(2);
    end

    // reset in the middle of a run
    preload(24'h000123);
    press(3'b001);
    step(3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    expect_all_zero("midrst");
    check_now();
    @(negedge clk);
    rst_n = 1'b1;
    scan_after_reset("midrst_rel");
    expect_val("midrst_lap", SIG_LAP, 0);
    check_now();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
